decode_cycle: RTL and testbench

//  Decode stage of the 5-stage RV64I pipeline; consumes the fetch stage's InstrD/PCD/PCPlus4D.

---
 rtl/decode_cycle_if.sv | 49 ++++
 rtl/decode_cycle.sv | 211 +++++++++++++++++++++
 tb/tb_decode_cycle.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_cycle_if.sv
// Decode-stage bus bundle: fetch inputs, writeback port and ID/EX outputs.
// Latency: n/a (wires only).
// Backpressure: none; the only stall-like control is FlushE.
//   slave  modport: the decode stage (consumes fetch/writeback, drives *E)
//   master modport: the surrounding pipeline / testbench
interface decode_cycle_if #(
    parameter int XLEN = 64
);
    // fetch side
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            FlushE;
    // writeback side
    logic            RegWriteW;
    logic [4:0]      RDW;
    logic [XLEN-1:0] ResultW;
    // ID/EX register outputs
    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            ALUSrcE;
    logic [2:0]      ALUControlE;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [4:0]      RS1E;
    logic [4:0]      RS2E;
    logic [4:0]      RDE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;

    modport slave (
        input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RDW, ResultW,
        output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE,
               PCE, PCPlus4E
    );

    modport master (
        output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RDW, ResultW,
        input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE,
               PCE, PCPlus4E
    );
endinterface

// File: rtl/decode_cycle.sv
// RV64I decode stage: register file, control/ALU decode, immediate extension.
// Latency: 1 cycle, InstrD/PCD/PCPlus4D -> registered *E outputs.
// Backpressure: none; FlushE loads a bubble into ID/EX, writeback is always honoured.
//   clk, rst : clock and asynchronous active-high reset
//   dif      : decode_cycle_if.slave (fetch inputs, writeback port, ID/EX outputs)
module decode_cycle #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    decode_cycle_if.slave dif
);
    localparam int NREG = 2 ** REG_AW;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [2:0]      alu_control;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } idex_t;

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    idex_t           idex_q, idex_d;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic            wr_en;

    assign instr  = dif.InstrD;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];
    assign wr_en  = dif.RegWriteW && (dif.RDW != 5'd0);

    // Register file write; x0 is never written so it stays zero after reset.
    always_comb begin
        rf_d = rf_q;
        if (wr_en) begin
            rf_d[dif.RDW[REG_AW-1:0]] = dif.ResultW;
        end
    end

    // Operand reads bypass a same-cycle writeback so W->D needs no extra stall.
    logic [XLEN-1:0] rd1, rd2;
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) begin
            rd1 = (wr_en && dif.RDW == rs1) ? dif.ResultW : rf_q[rs1[REG_AW-1:0]];
        end
        if (rs2 != 5'd0) begin
            rd2 = (wr_en && dif.RDW == rs2) ? dif.ResultW : rf_q[rs2[REG_AW-1:0]];
        end
    end

    // Main decode
    logic       reg_write, mem_write, branch, alu_src, jump;
    logic [1:0] result_src, alu_op;
    imm_src_t   imm_src;
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        jump       = 1'b0;
        result_src = 2'b00;
        alu_op     = 2'b00;
        imm_src    = IMM_NONE;
        case (opcode)
            OP_LD: begin
                reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; result_src = 2'b01;
            end
            OP_SD: begin
                imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1;
            end
            OP_R: begin
                reg_write = 1'b1; alu_op = 2'b10;
            end
            OP_I: begin
                reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; alu_op = 2'b10;
            end
            OP_B: begin
                imm_src = IMM_B; branch = 1'b1; alu_op = 2'b01;
            end
            OP_JAL: begin
                reg_write = 1'b1; imm_src = IMM_J; result_src = 2'b10; jump = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decode; instr[30] selects sub only for register-register ops,
    // since for addi that bit is part of the immediate.
    logic [2:0] alu_control;
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // Immediate extension
    logic [XLEN-1:0] imm_ext;
    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I: imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S: imm_ext = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm_ext = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm_ext = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    always_comb begin
        idex_d             = '0;
        idex_d.reg_write   = reg_write;
        idex_d.result_src  = result_src;
        idex_d.mem_write   = mem_write;
        idex_d.jump        = jump;
        idex_d.branch      = branch;
        idex_d.alu_src     = alu_src;
        idex_d.alu_control = alu_control;
        idex_d.funct3      = funct3;
        idex_d.rd1         = rd1;
        idex_d.rd2         = rd2;
        idex_d.imm_ext     = imm_ext;
        idex_d.rs1         = rs1;
        idex_d.rs2         = rs2;
        idex_d.rd          = rd;
        idex_d.pc          = dif.PCD;
        idex_d.pc_plus4    = dif.PCPlus4D;
        if (dif.FlushE) begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            idex_q <= idex_d;
            rf_q   <= rf_d;
        end
    end

    assign dif.RegWriteE   = idex_q.reg_write;
    assign dif.ResultSrcE  = idex_q.result_src;
    assign dif.MemWriteE   = idex_q.mem_write;
    assign dif.JumpE       = idex_q.jump;
    assign dif.BranchE     = idex_q.branch;
    assign dif.ALUSrcE     = idex_q.alu_src;
    assign dif.ALUControlE = idex_q.alu_control;
    assign dif.Funct3E     = idex_q.funct3;
    assign dif.RD1E        = idex_q.rd1;
    assign dif.RD2E        = idex_q.rd2;
    assign dif.ImmExtE     = idex_q.imm_ext;
    assign dif.RS1E        = idex_q.rs1;
    assign dif.RS2E        = idex_q.rs2;
    assign dif.RDE         = idex_q.rd;
    assign dif.PCE         = idex_q.pc;
    assign dif.PCPlus4E    = idex_q.pc_plus4;
endmodule

// File: tb/tb_decode_cycle.sv
module tb_decode_cycle;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_cycle_if #(.XLEN(64)) dif ();
    decode_cycle #(.XLEN(64), .REG_AW(5)) dut (.clk(clk), .rst(rst), .dif(dif));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rw;
        logic [1:0] rsrc;
        logic       mw, jmp, br, asrc;
        logic [2:0] alu, f3;
        longint     rd1, rd2, imm;
        logic [4:0] rs1, rs2, rd;
        logic [63:0] pc, pc4;
    } exp_t;

    exp_t        exp_q;
    logic [63:0] rf_m [32];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h @%0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.rw = 0; e.rsrc = 0; e.mw = 0; e.jmp = 0; e.br = 0; e.asrc = 0;
        e.alu = 0; e.f3 = 0; e.rd1 = 0; e.rd2 = 0; e.imm = 0;
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.pc = 0; e.pc4 = 0;
        return e;
    endfunction

    // Architectural register read as seen during decode (includes same-cycle writeback).
    function automatic longint read_reg(input logic [4:0] idx);
        if (idx == 0) return 0;
        if (dif.RegWriteW && dif.RDW == idx) return dif.ResultW;
        return rf_m[idx];
    endfunction

    // Reference decode written from the instruction-format tables with plain arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc,
                                     input logic [63:0] pc4);
        exp_t   e = zero_exp();
        longint sgn = ins[31] ? 1 : 0;
        e.f3  = ins[14:12];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.rd1 = read_reg(ins[19:15]);
        e.rd2 = read_reg(ins[24:20]);
        e.pc  = pc;
        e.pc4 = pc4;
        case (ins[6:0])
            7'h03: begin e.rw = 1; e.asrc = 1; e.rsrc = 2'b01;
                         e.imm = longint'(ins[31:20]) - sgn * 4096; end
            7'h23: begin e.mw = 1; e.asrc = 1;
                         e.imm = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - sgn * 2048; end
            7'h63: begin e.br = 1; e.alu = 3'd1;
                         e.imm = -sgn * 4096 + longint'(ins[7]) * 2048
                                 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2; end
            7'h6F: begin e.rw = 1; e.jmp = 1; e.rsrc = 2'b10;
                         e.imm = -sgn * (1 << 20) + longint'(ins[19:12]) * 4096
                                 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2; end
            7'h33, 7'h13: begin
                e.rw = 1;
                if (ins[6:0] == 7'h13) begin
                    e.asrc = 1;
                    e.imm  = longint'(ins[31:20]) - sgn * 4096;
                end
                case (ins[14:12])
                    3'd0: e.alu = (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
                    3'd2: e.alu = 3'd5;
                    3'd6: e.alu = 3'd3;
                    3'd7: e.alu = 3'd2;
                    default: e.alu = 3'd0;
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".ctrl"}, 64'({dif.RegWriteE, dif.ResultSrcE, dif.MemWriteE, dif.JumpE,
                                dif.BranchE, dif.ALUSrcE, dif.ALUControlE}),
            64'({exp_q.rw, exp_q.rsrc, exp_q.mw, exp_q.jmp, exp_q.br, exp_q.asrc, exp_q.alu}));
        chk({tag, ".idx"}, 64'({dif.Funct3E, dif.RS1E, dif.RS2E, dif.RDE}),
            64'({exp_q.f3, exp_q.rs1, exp_q.rs2, exp_q.rd}));
        chk({tag, ".rd1"}, dif.RD1E, exp_q.rd1);
        chk({tag, ".rd2"}, dif.RD2E, exp_q.rd2);
        chk({tag, ".imm"}, dif.ImmExtE, exp_q.imm);
        chk({tag, ".pc"},  dif.PCE, exp_q.pc);
        chk({tag, ".pc4"}, dif.PCPlus4E, exp_q.pc4);
    endtask

    task automatic model_reset();
        exp_q = zero_exp();
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
    endtask

    // One clock: model the edge, then compare on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            exp_q = dif.FlushE ? zero_exp() : ref_dec(dif.InstrD, dif.PCD, dif.PCPlus4D);
            if (dif.RegWriteW && dif.RDW != 0) rf_m[dif.RDW] = dif.ResultW;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic fl,
                         input logic we, input logic [4:0] rdw, input logic [63:0] res);
        dif.InstrD    = ins;
        dif.PCD       = pc;
        dif.PCPlus4D  = pc + 64'd4;
        dif.FlushE    = fl;
        dif.RegWriteW = we;
        dif.RDW       = rdw;
        dif.ResultW   = res;
    endtask

    logic [6:0] ops [7];

    initial begin
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
        ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h37;

        rst = 1'b1;
        drive(32'h0, 64'h0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // write x5, then add x7,x5,x5
        drive(32'h0, 64'h40, 0, 1, 5'd5, 64'hDEAD_BEEF);
        step("wr_x5");
        drive(32'h005283B3, 64'h44, 0, 0, 0, 0);
        step("add");
        chk("add.rd1", dif.RD1E, 64'hDEAD_BEEF);
        chk("add.rd2", dif.RD2E, 64'hDEAD_BEEF);
        chk("add.rde", 64'(dif.RDE), 64'd7);
        chk("add.rw",  64'(dif.RegWriteE), 64'd1);

        // asynchronous reset mid-stream, held across one edge
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        step("rst_hold");
        rst = 1'b0;
        drive(32'h005283B3, 64'h48, 0, 0, 0, 0);
        step("after_rst");
        chk("after_rst.rd1", dif.RD1E, 64'h0);

        // same-cycle write-through
        drive(32'h400300B3, 64'h4C, 0, 1, 5'd6, 64'h1234);
        step("sub_wt");
        chk("sub_wt.rd1", dif.RD1E, 64'h1234);
        chk("sub_wt.alu", 64'(dif.ALUControlE), 64'd1);

        // writes to x0 are dropped
        drive(32'hFFF00093, 64'h50, 0, 1, 5'd0, 64'hFF);
        step("addi_x0");
        chk("addi_x0.rd1", dif.RD1E, 64'h0);
        chk("addi_x0.imm", dif.ImmExtE, 64'hFFFF_FFFF_FFFF_FFFF);

        // branch, then the same branch flushed
        drive(32'hFE208CE3, 64'h54, 0, 0, 0, 0);
        step("beq");
        chk("beq.br",  64'(dif.BranchE), 64'd1);
        chk("beq.imm", dif.ImmExtE, 64'hFFFF_FFFF_FFFF_FFF8);
        drive(32'hFE208CE3, 64'h54, 1, 1, 5'd9, 64'h99);
        step("beq_flush");
        chk("beq_flush.br", 64'(dif.BranchE), 64'd0);

        // jal
        drive(32'h001000EF, 64'h100, 0, 0, 0, 0);
        step("jal");
        chk("jal.imm", dif.ImmExtE, 64'h800);
        chk("jal.pc4", dif.PCPlus4E, 64'h104);
        chk("jal.rsrc", 64'(dif.ResultSrcE), 64'd2);
        // x9 was written during the flushed cycle
        drive(32'h00048033, 64'h104, 0, 0, 0, 0);
        step("rd_x9");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 15) == 0) ins = 32'h0;
            drive(ins, {$urandom, $urandom}, ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 1) == 1, 5'($urandom), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) dif.RDW = ins[19:15];
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
